// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: opcodes, FSM states, NOP word.
package instr_encoder_pkg;

   typedef enum logic [6:0] {
      R_type      = 7'b0110011,
      I_type_load = 7'b0000011,
      I_type_arth = 7'b0010011,
      S_type      = 7'b0100011,
      SB_type     = 7'b1100011
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } enc_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer with immediate range check; unknown formats
// collapse to a flagged NOP.
module instr_field_packer
   import instr_encoder_pkg::*;
#(
   parameter int ARCH_REG_NUM_WIDTH = 5,
   parameter int IMM_WIDTH          = 32
) (
   input  opcode_t                       i_fmt,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] i_rd,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] i_rs1,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] i_rs2,
   input  logic [2:0]                    i_funct3,
   input  logic [6:0]                    i_funct7,
   input  logic [IMM_WIDTH-1:0]          i_imm,
   output logic [31:0]                   o_instr,
   output logic                          o_imm_err
);

   logic [4:0] w_rd, w_rs1, w_rs2;
   logic       w_i_ok, w_b_ok;

   assign w_rd  = i_rd[4:0];
   assign w_rs1 = i_rs1[4:0];
   assign w_rs2 = i_rs2[4:0];

   // A value fits in N signed bits when every bit from N-1 upward agrees.
   assign w_i_ok = (&i_imm[IMM_WIDTH-1:11]) | ~(|i_imm[IMM_WIDTH-1:11]);
   assign w_b_ok = ((&i_imm[IMM_WIDTH-1:12]) | ~(|i_imm[IMM_WIDTH-1:12])) & ~i_imm[0];

   always_comb begin
      o_instr   = NOP_INSTR;
      o_imm_err = 1'b0;
      case (i_fmt)
         R_type: begin
            o_instr = {i_funct7, w_rs2, w_rs1, i_funct3, w_rd, R_type};
         end
         I_type_load, I_type_arth: begin
            o_instr   = {i_imm[11:0], w_rs1, i_funct3, w_rd, i_fmt};
            o_imm_err = ~w_i_ok;
         end
         S_type: begin
            o_instr   = {i_imm[11:5], w_rs2, w_rs1, i_funct3, i_imm[4:0], S_type};
            o_imm_err = ~w_i_ok;
         end
         SB_type: begin
            o_instr   = {i_imm[12], i_imm[10:5], w_rs2, w_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], SB_type};
            o_imm_err = ~w_b_ok;
         end
         default: begin
            o_instr   = NOP_INSTR;
            o_imm_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams a bounded program of encoded RV32I words with sequential byte
// addresses; 1-cycle latency through a 2-entry (head + skid) output buffer.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ARCH_REG_NUM_WIDTH = 5,
   parameter int IMM_WIDTH          = 32,
   parameter int ADDR_WIDTH         = 32,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
   input  logic [CNT_WIDTH-1:0]          prog_len,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  opcode_t                       in_fmt,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] in_rd,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] in_rs1,
   input  logic [ARCH_REG_NUM_WIDTH-1:0] in_rs2,
   input  logic [2:0]                    in_funct3,
   input  logic [6:0]                    in_funct7,
   input  logic [IMM_WIDTH-1:0]          in_imm,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_instr,
   output logic [ADDR_WIDTH-1:0]         out_addr,
   output logic                          out_imm_err,
   output logic                          done
);

   enc_state_t            r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_remain;
   logic [ADDR_WIDTH-1:0] r_addr;

   // Head entry drives the outputs directly; the skid entry backs it up.
   logic                  r_out_valid, r_out_err;
   logic [31:0]           r_out_instr;
   logic [ADDR_WIDTH-1:0] r_out_addr;
   logic                  r_sk_valid, r_sk_err;
   logic [31:0]           r_sk_instr;
   logic [ADDR_WIDTH-1:0] r_sk_addr;
   logic                  r_done;

   logic [31:0] w_instr;
   logic        w_err;
   logic        w_push, w_pop, w_full;
   logic        w_in_ready, w_done_nxt, w_load;

   instr_field_packer #(
      .ARCH_REG_NUM_WIDTH (ARCH_REG_NUM_WIDTH),
      .IMM_WIDTH          (IMM_WIDTH)
   ) u_packer (
      .i_fmt     (in_fmt),
      .i_rd      (in_rd),
      .i_rs1     (in_rs1),
      .i_rs2     (in_rs2),
      .i_funct3  (in_funct3),
      .i_funct7  (in_funct7),
      .i_imm     (in_imm),
      .o_instr   (w_instr),
      .o_imm_err (w_err)
   );

   assign w_full = r_out_valid & r_sk_valid;
   assign w_pop  = r_out_valid & out_ready;
   assign w_push = in_valid & w_in_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (prog_len != '0) w_state_nxt = ST_RUN;
               else                w_done_nxt  = 1'b1;
            end
         end
         ST_RUN: begin
            w_in_ready = ~w_full & (r_remain != '0);
            if ((r_remain == '0) || (w_push && (r_remain == CNT_WIDTH'(1))))
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Empty once the skid is unused and the head leaves (or is absent).
            if (~r_sk_valid && (~r_out_valid || w_pop)) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_remain <= '0;
         r_addr   <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         if (w_load) begin
            r_remain <= prog_len;
            r_addr   <= base_addr;
         end else if (w_push) begin
            r_remain <= r_remain - CNT_WIDTH'(1);
            r_addr   <= r_addr + ADDR_WIDTH'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_addr  <= '0;
         r_out_err   <= 1'b0;
         r_sk_valid  <= 1'b0;
         r_sk_instr  <= '0;
         r_sk_addr   <= '0;
         r_sk_err    <= 1'b0;
      end else if (w_pop || ~r_out_valid) begin
         if (r_sk_valid) begin
            r_out_valid <= 1'b1;
            r_out_instr <= r_sk_instr;
            r_out_addr  <= r_sk_addr;
            r_out_err   <= r_sk_err;
            r_sk_valid  <= w_push;
            if (w_push) begin
               r_sk_instr <= w_instr;
               r_sk_addr  <= r_addr;
               r_sk_err   <= w_err;
            end
         end else begin
            r_out_valid <= w_push;
            if (w_push) begin
               r_out_instr <= w_instr;
               r_out_addr  <= r_addr;
               r_out_err   <= w_err;
            end
         end
      end else if (w_push) begin
         r_sk_valid <= 1'b1;
         r_sk_instr <= w_instr;
         r_sk_addr  <= r_addr;
         r_sk_err   <= w_err;
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_instr   = r_out_instr;
   assign out_addr    = r_out_addr;
   assign out_imm_err = r_out_err;
   assign done        = r_done;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, addresses, backpressure,
// done timing, mid-stream reset and start handling.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, out_ready;
   logic [31:0] base_addr;
   logic [15:0] prog_len;
   opcode_t     in_fmt;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        in_ready, out_valid, out_imm_err, done;
   logic [31:0] out_instr, out_addr;

   instr_encoder dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .prog_len(prog_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_imm_err(out_imm_err), .done(done)
   );

   initial forever #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, hs_cyc = -1, done_cyc = -1, done_cnt = 0, exp_done = 0;
   logic [31:0] q_instr[$];
   logic [31:0] q_addr[$];
   logic        q_err[$];
   logic        hold_v = 1'b0;
   logic [63:0] hold_val = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor: collects handshaken words, done pulses, and checks that
   // a stalled word holds steady until taken.
   initial forever begin
      @(negedge clk);
      if (hold_v && !reset) begin
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_word", {out_instr, out_addr}, hold_val);
      end
      if (out_valid && out_ready && !reset) begin
         q_instr.push_back(out_instr);
         q_addr.push_back(out_addr);
         q_err.push_back(out_imm_err);
         hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      hold_v   = out_valid && !out_ready && !reset;
      hold_val = {out_instr, out_addr};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] base, input logic [15:0] len);
      base_addr = base;
      prog_len  = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic send(input opcode_t f, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input logic [31:0] imm);
      int k;
      in_fmt    = f;
      in_rd     = 5'(rd);
      in_rs1    = 5'(rs1);
      in_rs2    = 5'(rs2);
      in_funct3 = 3'(f3);
      in_funct7 = 7'(f7);
      in_imm    = imm;
      in_valid  = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         check("send_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] ei,
                              input logic [31:0] ea, input logic ee);
      int k;
      k = 0;
      while (q_instr.size() == 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (q_instr.size() == 0) begin
         check({tag, "_timeout"}, 64'd0, 64'd1);
         return;
      end
      check({tag, "_instr"}, {32'd0, q_instr.pop_front()}, {32'd0, ei});
      check({tag, "_addr"},  {32'd0, q_addr.pop_front()},  {32'd0, ea});
      check({tag, "_err"},   {63'd0, q_err.pop_front()},   {63'd0, ee});
   endtask

   task automatic wait_done(input string tag, input bit timed);
      int k;
      k = 0;
      while (done_cnt <= exp_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt <= exp_done) begin
         check({tag, "_done_timeout"}, 64'd0, 64'd1);
         return;
      end
      exp_done++;
      if (timed) check({tag, "_done_lat"}, 64'(done_cyc), 64'(hs_cyc + 1));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      base_addr = '0; prog_len = '0; in_fmt = R_type;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_word", {out_instr, out_addr}, 64'd0);
      check("rst_err_done_rdy", {61'd0, out_imm_err, done, in_ready}, 64'd0);
      reset = 1'b0;
      tick();

      // single I-type word
      do_start(32'h100, 16'd1);
      send(I_type_arth, 1, 2, 0, 0, 0, -1);
      expect_word("t1", 32'hFFF10093, 32'h100, 1'b0);
      wait_done("t1", 1'b1);

      // S then SB
      do_start(32'h200, 16'd2);
      send(S_type, 0, 2, 5, 2, 0, 8);
      send(SB_type, 0, 1, 2, 0, 0, -4);
      expect_word("t2_s",  32'h00512423, 32'h200, 1'b0);
      expect_word("t2_sb", 32'hFE208EE3, 32'h204, 1'b0);
      wait_done("t2", 1'b1);

      // range violations and unknown format still emitted and counted
      do_start(32'h300, 16'd3);
      send(I_type_arth, 1, 2, 0, 0, 0, 2048);
      send(SB_type, 0, 1, 2, 0, 0, 3);
      send(opcode_t'(7'h7F), 1, 2, 3, 0, 0, 0);
      expect_word("t3_i2048", 32'h80010093, 32'h300, 1'b1);
      expect_word("t3_sb3",   32'h00208163, 32'h304, 1'b1);
      expect_word("t3_unk",   32'h00000013, 32'h308, 1'b1);
      wait_done("t3", 1'b1);

      // boundaries, R-type ignoring imm, address wrap
      do_start(32'hFFFFFFF8, 16'd8);
      send(R_type, 3, 1, 2, 0, 7'h00, 32'h12345678);
      send(R_type, 3, 1, 2, 0, 7'h20, 32'h80000000);
      send(I_type_load, 5, 10, 0, 2, 0, -2048);
      send(I_type_arth, 1, 2, 0, 0, 0, 2047);
      send(I_type_arth, 1, 2, 0, 0, 0, -2049);
      send(SB_type, 0, 1, 2, 0, 0, 4094);
      send(SB_type, 0, 1, 2, 0, 0, -4096);
      send(SB_type, 0, 1, 2, 0, 0, 4096);
      expect_word("t4_add",  32'h002081B3, 32'hFFFFFFF8, 1'b0);
      expect_word("t4_sub",  32'h402081B3, 32'hFFFFFFFC, 1'b0);
      expect_word("t4_lw",   32'h80052283, 32'h00000000, 1'b0);
      expect_word("t4_i2047", 32'h7FF10093, 32'h00000004, 1'b0);
      expect_word("t4_im2049", 32'h7FF10093, 32'h00000008, 1'b1);
      expect_word("t4_sb4094", 32'h7E208FE3, 32'h0000000C, 1'b0);
      expect_word("t4_sbm4096", 32'h80208063, 32'h00000010, 1'b0);
      expect_word("t4_sb4096", 32'h80208063, 32'h00000014, 1'b1);
      wait_done("t4", 1'b1);

      // backpressure: buffer fills at two words
      out_ready = 1'b0;
      do_start(32'h400, 16'd4);
      send(I_type_arth, 1, 0, 0, 0, 0, 1);
      send(I_type_arth, 2, 0, 0, 0, 0, 2);
      check("t5_full_rdy", {63'd0, in_ready}, 64'd0);
      tick();
      check("t5_full_rdy2", {63'd0, in_ready}, 64'd0);
      check("t5_head", {out_instr, out_addr}, {32'h00100093, 32'h400});
      out_ready = 1'b1;
      send(I_type_arth, 3, 0, 0, 0, 0, 3);
      send(I_type_arth, 4, 0, 0, 0, 0, 4);
      expect_word("t5_w0", 32'h00100093, 32'h400, 1'b0);
      expect_word("t5_w1", 32'h00200113, 32'h404, 1'b0);
      expect_word("t5_w2", 32'h00300193, 32'h408, 1'b0);
      expect_word("t5_w3", 32'h00400213, 32'h40C, 1'b0);
      wait_done("t5", 1'b1);

      // reset with one word buffered
      out_ready = 1'b0;
      do_start(32'h500, 16'd3);
      send(I_type_arth, 1, 2, 0, 0, 0, 5);
      check("t6_buffered", {63'd0, out_valid}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
      check("t6_rst_word", {out_instr, out_addr}, 64'd0);
      check("t6_rst_rdy", {62'd0, in_ready, done}, 64'd0);
      out_ready = 1'b1;
      tick();
      do_start(32'h600, 16'd1);
      send(I_type_load, 5, 10, 0, 2, 0, -2048);
      expect_word("t6_new", 32'h80052283, 32'h600, 1'b0);
      wait_done("t6", 1'b1);

      // zero-length program
      do_start(32'h700, 16'd0);
      check("t7_len0_done", {62'd0, done, out_valid}, {62'd0, 1'b1, 1'b0});
      check("t7_len0_rdy", {63'd0, in_ready}, 64'd0);
      wait_done("t7", 1'b0);
      tick();
      check("t7_done_pulse", {63'd0, done}, 64'd0);

      // start during RUN is ignored
      do_start(32'h800, 16'd2);
      send(I_type_arth, 1, 0, 0, 0, 0, 1);
      do_start(32'h900, 16'd5);
      send(I_type_arth, 2, 0, 0, 0, 0, 2);
      expect_word("t8_a", 32'h00100093, 32'h800, 1'b0);
      expect_word("t8_b", 32'h00200113, 32'h804, 1'b0);
      wait_done("t8", 1'b1);
      repeat (3) tick();
      check("t8_idle_rdy", {63'd0, in_ready}, 64'd0);
      check("leftover_words", 64'(q_instr.size()), 64'd0);
      check("done_total", 64'(done_cnt), 64'(exp_done));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the ID-stage immediate generator: packs decoded fields (format, registers, funct, signed immediate) into 32-bit RV32I instruction words.
- Streams a bounded program of encoded words, each tagged with a sequential byte address, into instruction memory / the fetch preload path.
- Used by the self-test program loader and by verification for round-trip checks against the ID-stage decode.

Parameters:
- ARCH_REG_NUM_WIDTH, `ARCH_REG_NUM_WIDTH, register-index width (5).
- IMM_WIDTH, `REG_VAL_WIDTH, width of the signed immediate input (32).
- ADDR_WIDTH, 32, output address width.
- CNT_WIDTH, 16, program-length counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches base_addr and prog_len.
- base_addr  in  ADDR_WIDTH  address of the first word; must be 4-aligned.
- prog_len  in  CNT_WIDTH  number of words to emit.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle.
- in_fmt  in  opcode_t  R_type / I_type_load / I_type_arth / S_type / SB_type.
- in_rd, in_rs1, in_rs2  in  ARCH_REG_NUM_WIDTH  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; R-type only.
- in_imm  in  IMM_WIDTH  signed immediate.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  sink accepts the word.
- out_instr  out  32  encoded instruction word.
- out_addr  out  ADDR_WIDTH  byte address of out_instr.
- out_imm_err  out  1  immediate out of range, or odd SB offset.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- FSM states:
  - IDLE: in_ready = 0. On start: go to RUN if prog_len != 0, else pulse done and stay in IDLE.
  - RUN: accept bundles until prog_len words have been accepted on the input side, then go to DRAIN.
  - DRAIN: in_ready = 0. When the buffer is empty and the last output handshake has completed, pulse done and go to IDLE.
  - start is ignored outside IDLE.
- Encoding per format (standard RV32I bit positions):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I_type_load / I_type_arth: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - SB: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - Unknown in_fmt: emit 0x00000013 (NOP) with out_imm_err = 1.
- Immediate range check:
  - I and S: legal range is -2048..2047.
  - SB: legal range is -4096..4094, and imm[0] must be 0.
  - R: in_imm is ignored and never flags.
  - On violation: encode the truncated low bits and set out_imm_err = 1; the word is still emitted and still counted.
- Pipeline: 1-cycle latency, registered outputs, 2-entry output buffer.
  - in_ready = (state == RUN) && (buffer not full) && (remaining count != 0).
  - Input handshake on in_valid && in_ready; output handshake on out_valid && out_ready.
  - A word accepted in cycle N appears on out_* in cycle N+1 at the earliest.
  - out_* hold stable while out_valid && !out_ready.
  - Simultaneous push and pop on a full buffer is legal and keeps the buffer full; words are never dropped or reordered.
- Addressing: the address counter loads base_addr on start and increments by 4 on each input acceptance. It wraps modulo 2^ADDR_WIDTH without error.
- Reset (including mid-stream): state = IDLE; buffer flushed; out_valid = 0, out_instr = 0, out_addr = 0, out_imm_err = 0, done = 0, in_ready = 0; all counters cleared. Partially emitted programs are discarded.
- Invariant: when out_imm_err = 0, decoding out_instr through the ID-stage immediate path returns sign-extended in_imm.

Decomposition:
- Shared package: opcode_t and its values (R_type 0110011, I_type_load 0000011, I_type_arth 0010011, S_type 0100011, SB_type 1100011), plus NOP_INSTR = 32'h00000013.
- Sub-module instr_field_packer: combinational packing and range check.
- instr_encoder itself holds the FSM, counters and the 2-entry buffer.

Test Plan:
- start base=0x100 len=1; I_type_arth rd=1 rs1=2 f3=0 imm=-1 -> out_instr=0xFFF10093, out_addr=0x100, err=0, then done pulse.
- start len=2; S rs1=2 rs2=5 f3=2 imm=8, then SB rs1=1 rs2=2 f3=0 imm=-4 -> 0x00512423 @base, 0xFE208EE3 @base+4.
- I_type_arth imm=2048; SB imm=3 -> both words emitted, err=1; I field=0x800.
- len=4, out_ready held low 3 cycles after first accept -> in_ready drops once 2 words are buffered; all 4 words delivered in order with correct addresses; done one cycle after the 4th handshake.
- reset asserted while 1 word is buffered mid-stream -> next cycle out_valid=0, state IDLE; a new start begins cleanly at the new base_addr.
- start with len=0 -> done pulses immediately, no out_valid; start asserted during RUN -> ignored.
